// File: rtl/imem_access_sequencer.sv
// -----------------------------------------------------------------------------
// imem_access_sequencer
//
// Purpose:
//   Owns the single byte-wide instruction memory port and shares it between
//   the I2C programming path (single byte writes) and the core fetch path
//   (multi-byte instruction reads). i_prog_mode selects the only requester
//   that is served, so the two paths never compete.
//   A fetch reads BYTES_PER_INST consecutive bytes starting at the aligned
//   fetch address and assembles them little-endian into o_instr.
//
// Ports:
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_prog_mode                     1 = programming (writes), 0 = run (fetches)
//   i_wr_req/i_wr_addr/i_wr_data    write request, held until o_wr_ack
//   o_wr_ack                        one-cycle pulse, write committed this cycle
//   i_fetch_req/i_fetch_pc          fetch request, sampled only when idle
//   o_fetch_busy                    a fetch is being sequenced
//   o_fetch_valid                   one-cycle pulse, o_instr was just updated
//   o_instr                         assembled instruction word
//   o_wr_count                      committed write counter (wraps)
//   o_mem_addr/o_mem_wdata          memory address / write data
//   o_mem_we/o_mem_re               memory write / read enables
//   i_mem_rdata                     read data, one cycle after o_mem_re
//
// Handshake: a write request is level-held by the requester; the block accepts
//   it only in IDLE and answers with exactly one o_wr_ack pulse in the cycle the
//   memory write happens. The requester may drop or replace the request in the
//   cycle after the ack.
// -----------------------------------------------------------------------------
module imem_access_sequencer #(
  parameter int ADDR_W         = 8,
  parameter int BYTES_PER_INST = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_prog_mode,
  input  logic                          i_wr_req,
  input  logic [ADDR_W-1:0]             i_wr_addr,
  input  logic [7:0]                    i_wr_data,
  output logic                          o_wr_ack,
  input  logic                          i_fetch_req,
  input  logic [ADDR_W-1:0]             i_fetch_pc,
  output logic                          o_fetch_busy,
  output logic                          o_fetch_valid,
  output logic [8*BYTES_PER_INST-1:0]   o_instr,
  output logic [7:0]                    o_wr_count,
  output logic [ADDR_W-1:0]             o_mem_addr,
  output logic [7:0]                    o_mem_wdata,
  output logic                          o_mem_we,
  output logic                          o_mem_re,
  input  logic [7:0]                    i_mem_rdata
);

  localparam int K_W = $clog2(BYTES_PER_INST);
  localparam int IW  = 8 * BYTES_PER_INST;
  localparam logic [K_W-1:0]    K_LAST     = K_W'(BYTES_PER_INST - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES_PER_INST - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [K_W-1:0]      r_k;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [7:0]          r_wr_data;
  logic [7:0]          r_wr_count;
  // Bytes 0..BYTES_PER_INST-2; the last byte goes straight into o_instr in DONE.
  logic [IW-9:0]       r_buf;
  logic [IW-1:0]       r_instr;
  logic                r_fetch_valid;

  logic                w_wr_ack;
  logic                w_mem_we;
  logic                w_mem_re;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [7:0]          w_mem_wdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_k           <= '0;
      r_base        <= '0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_wr_count    <= '0;
      r_buf         <= '0;
      r_instr       <= '0;
      r_fetch_valid <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_fetch_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_prog_mode && i_wr_req) begin
            r_wr_addr <= i_wr_addr;
            r_wr_data <= i_wr_data;
          end else if (!i_prog_mode && i_fetch_req) begin
            r_base <= i_fetch_pc & ALIGN_MASK;
            r_k    <= '0;
          end
        end
        S_WR: begin
          r_wr_count <= r_wr_count + 8'd1;
        end
        S_RD: begin
          if (!i_prog_mode) begin
            // Data for the read issued in the previous RD cycle arrives now.
            for (int j = 0; j < BYTES_PER_INST - 1; j++) begin
              if (int'(r_k) == j + 1) begin
                r_buf[8*j +: 8] <= i_mem_rdata;
              end
            end
            r_k <= r_k + K_W'(1);
          end
        end
        S_DONE: begin
          // A mode change here aborts: o_instr keeps its old value, no pulse.
          if (!i_prog_mode) begin
            r_instr       <= {i_mem_rdata, r_buf};
            r_fetch_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next      = r_state;
    w_wr_ack    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_re    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (i_prog_mode && i_wr_req) begin
          w_next = S_WR;
        end else if (!i_prog_mode && i_fetch_req) begin
          w_next = S_RD;
        end
      end
      S_WR: begin
        // Completes regardless of i_prog_mode in this cycle.
        w_mem_we    = 1'b1;
        w_mem_addr  = r_wr_addr;
        w_mem_wdata = r_wr_data;
        w_wr_ack    = 1'b1;
        w_next      = S_IDLE;
      end
      S_RD: begin
        w_mem_re = 1'b1;
        // Base low bits are zero, so OR-ing the index never carries or wraps.
        w_mem_addr = r_base | ADDR_W'(r_k);
        if (i_prog_mode) begin
          w_next = S_IDLE;
        end else if (r_k == K_LAST) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign o_wr_ack      = w_wr_ack;
  assign o_mem_we      = w_mem_we;
  assign o_mem_re      = w_mem_re;
  assign o_mem_addr    = w_mem_addr;
  assign o_mem_wdata   = w_mem_wdata;
  assign o_fetch_busy  = (r_state == S_RD) || (r_state == S_DONE);
  assign o_fetch_valid = r_fetch_valid;
  assign o_instr       = r_instr;
  assign o_wr_count    = r_wr_count;

endmodule

// File: tb/tb_imem_access_sequencer.sv
// -----------------------------------------------------------------------------
// tb_imem_access_sequencer
//   Drives the sequencer against a byte memory responder. Expected instruction
//   words come from a reference byte array that the bench updates whenever it
//   issues a write; fetch results are checked by a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_imem_access_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_prog_mode = 1'b0;
  logic        i_wr_req = 1'b0;
  logic [7:0]  i_wr_addr = 8'h00;
  logic [7:0]  i_wr_data = 8'h00;
  logic        o_wr_ack;
  logic        i_fetch_req = 1'b0;
  logic [7:0]  i_fetch_pc = 8'h00;
  logic        o_fetch_busy;
  logic        o_fetch_valid;
  logic [31:0] o_instr;
  logic [7:0]  o_wr_count;
  logic [7:0]  o_mem_addr;
  logic [7:0]  o_mem_wdata;
  logic        o_mem_we;
  logic        o_mem_re;
  logic [7:0]  i_mem_rdata = 8'h00;

  imem_access_sequencer #(.ADDR_W(8), .BYTES_PER_INST(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_prog_mode(i_prog_mode),
    .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .o_wr_ack(o_wr_ack), .i_fetch_req(i_fetch_req), .i_fetch_pc(i_fetch_pc),
    .o_fetch_busy(o_fetch_busy), .o_fetch_valid(o_fetch_valid),
    .o_instr(o_instr), .o_wr_count(o_wr_count), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we), .o_mem_re(o_mem_re),
    .i_mem_rdata(i_mem_rdata)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory responder ----------------
  logic [7:0] mem [256];
  always @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      i_mem_rdata <= 8'h00;
    end else begin
      if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
      if (o_mem_re) i_mem_rdata <= mem[o_mem_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  ref_mem [256];
  logic [7:0]  exp_wr_count = 8'h00;
  logic [31:0] last_instr = 32'h0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  always @(negedge i_clk) begin
    logic [31:0] e;
    if (!i_rst) begin
      check("we_re_exclusive", 64'(o_mem_we & o_mem_re), 64'd0);
      if (o_fetch_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'(o_fetch_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("fetch_instr", 64'(o_instr), 64'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a rising edge with the DUT idle.
  task automatic do_write(input logic [7:0] a, input logic [7:0] d, output int ack_cyc);
    int n;
    ack_cyc = -1;
    n = 0;
    i_prog_mode = 1'b1; i_fetch_req = 1'b0;
    i_wr_req = 1'b1; i_wr_addr = a; i_wr_data = d;
    while (n < 10 && ack_cyc < 0) begin
      @(negedge i_clk);
      if (o_wr_ack) begin
        ack_cyc = cyc;
        check("wr_mem_we", 64'(o_mem_we), 64'd1);
        check("wr_mem_addr_data", 64'({o_mem_addr, o_mem_wdata}), 64'({a, d}));
      end
      @(posedge i_clk); #1;
      n++;
    end
    check("wr_ack_seen", 64'(ack_cyc >= 0), 64'd1);
    ref_mem[a] = d;
    exp_wr_count = exp_wr_count + 8'd1;
  endtask

  task automatic do_fetch(input logic [7:0] pc, input logic [7:0] exp_base,
                          input logic [31:0] exp_instr);
    int n, nre, got;
    exp_q.push_back(exp_instr);
    i_prog_mode = 1'b0; i_wr_req = 1'b0;
    i_fetch_req = 1'b1; i_fetch_pc = pc;
    @(posedge i_clk); #1;
    i_fetch_req = 1'b0;
    i_fetch_pc = 8'($urandom);       // must not disturb the fetch in flight
    n = 1; nre = 0; got = 0;
    while (n <= 20 && got == 0) begin
      @(negedge i_clk);
      if (o_mem_re) begin
        check("fetch_addr", 64'(o_mem_addr), 64'(exp_base) + 64'(nre));
        nre++;
      end
      if (o_fetch_valid) got = n;
      @(posedge i_clk); #1;
      n++;
    end
    check("fetch_latency", 64'(got), 64'd6);
    check("fetch_reads", 64'(nre), 64'd4);
    last_instr = exp_instr;
  endtask

  function automatic logic [31:0] ref_instr(input logic [7:0] pc);
    logic [7:0] b;
    b = pc & 8'hFC;
    return {ref_mem[b + 8'd3], ref_mem[b + 8'd2], ref_mem[b + 8'd1], ref_mem[b]};
  endfunction

  // ---------------- vector tables ----------------
  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_count;
  } wr_vec_t;

  typedef struct {
    logic [7:0]  pc;
    logic [7:0]  exp_base;
    logic [31:0] exp_instr;
  } fetch_vec_t;

  wr_vec_t    wr_tab [8];
  fetch_vec_t fe_tab [5];

  // ---------------- test sequence ----------------
  initial begin
    int ack, prev_ack, t_raise, n, viol;
    logic [7:0] a, d;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

    wr_tab[0] = '{8'h10, 8'h11, 8'd1};
    wr_tab[1] = '{8'h11, 8'h22, 8'd2};
    wr_tab[2] = '{8'h12, 8'h33, 8'd3};
    wr_tab[3] = '{8'h13, 8'h44, 8'd4};
    wr_tab[4] = '{8'hFC, 8'hAA, 8'd5};
    wr_tab[5] = '{8'hFD, 8'hBB, 8'd6};
    wr_tab[6] = '{8'hFE, 8'hCC, 8'd7};
    wr_tab[7] = '{8'hFF, 8'hDD, 8'd8};

    fe_tab[0] = '{8'h12, 8'h10, 32'h44332211};
    fe_tab[1] = '{8'h10, 8'h10, 32'h44332211};
    fe_tab[2] = '{8'hFE, 8'hFC, 32'hDDCCBBAA};
    fe_tab[3] = '{8'hFF, 8'hFC, 32'hDDCCBBAA};
    fe_tab[4] = '{8'h13, 8'h10, 32'h44332211};

    // Power-on reset
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("reset_outputs",
          64'({o_fetch_busy, o_fetch_valid, o_wr_ack, o_mem_we, o_mem_re,
               o_mem_addr, o_mem_wdata, o_wr_count}), 64'd0);
    check("reset_instr", 64'(o_instr), 64'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // Back-to-back programming writes: acks 2 cycles apart, counter steps
    prev_ack = 0;
    for (int i = 0; i < 8; i++) begin
      do_write(wr_tab[i].addr, wr_tab[i].data, ack);
      if (i > 0) check("wr_ack_gap", 64'(ack - prev_ack), 64'd2);
      check("wr_count", 64'(o_wr_count), 64'(wr_tab[i].exp_count));
      prev_ack = ack;
    end
    i_wr_req = 1'b0;

    // Fetches, including the top-of-memory group
    for (int i = 0; i < 5; i++) begin
      do_fetch(fe_tab[i].pc, fe_tab[i].exp_base, fe_tab[i].exp_instr);
    end
    check("instr_after_fetches", 64'(o_instr), 64'(last_instr));

    // Abort: prog mode rises in RD k=1 with a write pending
    i_prog_mode = 1'b0; i_fetch_req = 1'b1; i_fetch_pc = 8'h10;
    @(posedge i_clk); #1;
    i_fetch_req = 1'b0;
    @(posedge i_clk); #1;
    i_prog_mode = 1'b1; i_wr_req = 1'b1; i_wr_addr = 8'h30; i_wr_data = 8'h5A;
    t_raise = cyc;
    @(negedge i_clk);
    check("abort_rd1_addr", 64'({o_fetch_busy, o_mem_re, o_mem_addr}), 64'({1'b1, 1'b1, 8'h11}));
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check("abort_idle", 64'({o_fetch_busy, o_mem_re}), 64'd0);
    ack = -1; n = 0;
    while (n < 10 && ack < 0) begin
      if (o_wr_ack) ack = cyc;
      else begin @(negedge i_clk); n++; end
    end
    check("abort_wr_ack_delay", 64'(ack - t_raise), 64'd2);
    @(posedge i_clk); #1;
    i_wr_req = 1'b0;
    ref_mem[8'h30] = 8'h5A;
    exp_wr_count = exp_wr_count + 8'd1;
    repeat (8) @(posedge i_clk);
    #1;
    check("abort_instr_kept", 64'(o_instr), 64'(last_instr));
    check("abort_wr_count", 64'(o_wr_count), 64'(exp_wr_count));

    // Reset in the middle of a fetch (RD k=2)
    i_prog_mode = 1'b0; i_fetch_req = 1'b1; i_fetch_pc = 8'hFC;
    @(posedge i_clk); #1;
    i_fetch_req = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check("midfetch_reset_outputs",
          64'({o_fetch_busy, o_fetch_valid, o_wr_ack, o_mem_we, o_mem_re,
               o_mem_addr, o_mem_wdata, o_wr_count}), 64'd0);
    check("midfetch_reset_instr", 64'(o_instr), 64'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    exp_wr_count = 8'h00;
    last_instr = 32'h0;
    @(posedge i_clk); #1;

    // Requests from the non-owning side are ignored
    viol = 0;
    i_prog_mode = 1'b0; i_wr_req = 1'b1; i_wr_addr = 8'h05; i_wr_data = 8'h77;
    repeat (10) begin
      @(negedge i_clk);
      if (o_wr_ack || o_mem_we || o_mem_re) viol++;
    end
    @(posedge i_clk); #1;
    i_wr_req = 1'b0;
    check("run_mode_wr_ignored", 64'(viol), 64'd0);
    check("run_mode_wr_count", 64'(o_wr_count), 64'(exp_wr_count));

    viol = 0;
    i_prog_mode = 1'b1; i_fetch_req = 1'b1; i_fetch_pc = 8'h20;
    repeat (10) begin
      @(negedge i_clk);
      if (o_fetch_busy || o_fetch_valid || o_mem_re || o_mem_we) viol++;
    end
    @(posedge i_clk); #1;
    i_fetch_req = 1'b0;
    check("prog_mode_fetch_ignored", 64'(viol), 64'd0);
    check("prog_mode_instr", 64'(o_instr), 64'(last_instr));

    // Random mix of writes and fetches against the reference array
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = 8'($urandom_range(0, 255));
        d = 8'($urandom_range(0, 255));
        do_write(a, d, ack);
        i_wr_req = 1'b0;
        check("rand_wr_count", 64'(o_wr_count), 64'(exp_wr_count));
      end else begin
        a = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) a = {a[7:3], 3'b000} | 8'h00;
        do_fetch(a, a & 8'hFC, ref_instr(a));
      end
    end

    repeat (4) @(posedge i_clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
